lab2_proc_req_tracker: RTL
==========================

# lab2_proc_req_tracker

Request-side companion to the response drop logic in the lab 2 pipelined processor. It sits between a processor memory port (fetch or data) and the memory interface, forwards requests, and counts outstanding transactions. On a squash it marks every outstanding request as stale and silently consumes the matching late responses. This supports up to `p_max_inflight` outstanding requests instead of a single dropped packet.

## Interface

Parameters:
- `p_req_nbits`, default 77: memory request message width.
- `p_resp_nbits`, default 47: memory response message width.
- `p_max_inflight`, default 4: maximum outstanding requests; must be at least 1.
- `c_cnt_nbits` (localparam), `$clog2(p_max_inflight+1)`: counter width.

Ports:
- `clk`, in, 1: the single clock.
- `reset`, in, 1: reset, asynchronous, active-high.
- `squash`, in, 1: the pipeline squashed all instructions with outstanding requests.
- `ireq_msg`, in, `p_req_nbits`: request from the processor.
- `ireq_val`, in, 1: request valid.
- `ireq_rdy`, out, 1: request accepted.
- `memreq_msg`, out, `p_req_nbits`: request to memory.
- `memreq_val`, out, 1: request to memory valid.
- `memreq_rdy`, in, 1: memory accepts the request.
- `memresp_msg`, in, `p_resp_nbits`: response from memory.
- `memresp_val`, in, 1: response from memory valid.
- `memresp_rdy`, out, 1: response from memory accepted.
- `oresp_msg`, out, `p_resp_nbits`: response to the processor.
- `oresp_val`, out, 1: response to the processor valid.
- `oresp_rdy`, in, 1: processor accepts the response.
- `num_inflight`, out, `c_cnt_nbits`: current outstanding count (debug and stall logic).

## Operation

State:
- `inflight` counter.
- `drop_cnt` counter.
- Invariant: `drop_cnt` ≤ `inflight` ≤ `p_max_inflight`.

Request path:
- `full` = (`inflight` == `p_max_inflight`).
- `memreq_msg` = `ireq_msg`.
- `memreq_val` = `ireq_val` && !`full`.
- `ireq_rdy` = `memreq_rdy` && !`full`.
- `req_go` = `memreq_val` && `memreq_rdy`.
- `full` blocks issue even if a response completes in the same cycle (no same-cycle slot reuse).

Response path:
- `oresp_msg` = `memresp_msg`.
- If `drop_cnt` != 0 or `squash`: `oresp_val` = 0, `memresp_rdy` = 1. The response is dropped.
- Otherwise: `oresp_val` = `memresp_val`, `memresp_rdy` = `oresp_rdy`.
- `resp_go` = `memresp_val` && `memresp_rdy`.

Counter updates:
- `inflight_next` = `inflight` + `req_go` − `resp_go`.
- If `squash`: `drop_cnt_next` = `inflight_next`. Every outstanding request, including one issued this cycle, becomes stale. A response consumed this cycle is already excluded.
- Otherwise, if `resp_go` && `drop_cnt` != 0: `drop_cnt_next` = `drop_cnt` − 1.
- Otherwise: `drop_cnt` holds.

Boundary conditions:
- Squash while `drop_cnt` > 0: recompute from `inflight_next`; old and new stale requests merge.
- Squash with `inflight` == 0 and no `req_go`: `drop_cnt` stays 0.
- Repeated squash on consecutive cycles: idempotent.
- A response arriving with `inflight` == 0 is a protocol violation. Behaviour is unspecified, and the bench flags it.
- Reset mid-operation clears both counters. Memory responses still in flight are then the caller's responsibility.

## Timing

- Both paths are combinational pass-through, zero cycle latency. There are no registers on the message paths.
- Counters update on `posedge clk`.
- Async reset sets `inflight` = 0 and `drop_cnt` = 0 immediately.
- Outputs during and after reset:
  - `num_inflight` = 0.
  - `memreq_val` = `ireq_val`.
  - `ireq_rdy` = `memreq_rdy`.
  - `oresp_val` = `memresp_val` && !`squash`.
- A dropped response completes in the cycle it is presented: `memresp_rdy` = 1 regardless of `oresp_rdy`.
- The first surviving response is forwarded in the cycle after `drop_cnt` reaches 0.

## Configuration

- `LAB2_PROC_REQ_TRACKER_SQUASH_GATE_EN`
  - Defined: `squash` also gates the request path. `memreq_val` = `ireq_val` && !`full` && !`squash` and `ireq_rdy` = `memreq_rdy` && !`full` && !`squash`. No stale request is issued in the squash cycle.
  - Undefined: a request in the squash cycle is issued and counted into `drop_cnt`.

## Test plan

- Pass-through: issue 3 requests with `memreq_rdy` = 1 and return 3 responses with `oresp_rdy` = 1. `num_inflight` goes 1, 2, 3, 2, 1, 0, and all responses are forwarded unchanged in the same cycle.
- Full stall (`p_max_inflight` = 4): issue 4 requests with no responses. `ireq_rdy` = 0 and `memreq_val` = 0 on the fifth. After one response, the fifth issues in the following cycle.
- Squash with 3 outstanding: assert `squash` for one cycle with no traffic. `drop_cnt` = 3, the next 3 responses have `oresp_val` = 0 and `memresp_rdy` = 1 even with `oresp_rdy` = 0, and the fourth is forwarded.
- Simultaneous events: `inflight` = 2, `squash` with a response and a request in the same cycle. Macro undefined gives `drop_cnt` = 2 and `inflight` = 2. Macro defined gives no request, `drop_cnt` = 1 and `inflight` = 1.
- Back-pressure: `oresp_rdy` = 0 with `drop_cnt` = 0 gives `memresp_rdy` = 0 and the counters hold. A second squash while `drop_cnt` = 1 and a new request is outstanding gives `drop_cnt` = 2.
- Async reset: assert `reset` mid-cycle with `inflight` = 3 and `drop_cnt` = 2. `num_inflight` reads 0 before the next clock edge, and a subsequent response is forwarded.

Source files
------------

// File: rtl/lab2_proc_req_tracker.sv
// Request tracker: forwards memory requests, counts outstanding ones and drops stale responses
// after a squash. Define LAB2_PROC_REQ_TRACKER_SQUASH_GATE_EN to also block requests on squash.
module lab2_proc_req_tracker #(
  parameter int unsigned p_req_nbits    = 77,
  parameter int unsigned p_resp_nbits   = 47,
  parameter int unsigned p_max_inflight = 4,
  localparam int unsigned c_cnt_nbits   = $clog2(p_max_inflight + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    squash,

  input  logic [p_req_nbits-1:0]  ireq_msg,
  input  logic                    ireq_val,
  output logic                    ireq_rdy,

  output logic [p_req_nbits-1:0]  memreq_msg,
  output logic                    memreq_val,
  input  logic                    memreq_rdy,

  input  logic [p_resp_nbits-1:0] memresp_msg,
  input  logic                    memresp_val,
  output logic                    memresp_rdy,

  output logic [p_resp_nbits-1:0] oresp_msg,
  output logic                    oresp_val,
  input  logic                    oresp_rdy,

  output logic [c_cnt_nbits-1:0]  num_inflight
);

  localparam logic [c_cnt_nbits-1:0] MaxCnt = c_cnt_nbits'(p_max_inflight);

  logic [c_cnt_nbits-1:0] inflight_q, inflight_d;
  logic [c_cnt_nbits-1:0] drop_q, drop_d;
  logic                   full;
  logic                   dropping;
  logic                   req_go;
  logic                   resp_go;

  assign full     = (inflight_q == MaxCnt);
  assign dropping = (drop_q != '0) || squash;

  assign memreq_msg = ireq_msg;
  assign oresp_msg  = memresp_msg;

`ifdef LAB2_PROC_REQ_TRACKER_SQUASH_GATE_EN
  assign memreq_val = ireq_val && !full && !squash;
  assign ireq_rdy   = memreq_rdy && !full && !squash;
`else
  assign memreq_val = ireq_val && !full;
  assign ireq_rdy   = memreq_rdy && !full;
`endif

  // Stale responses are swallowed without waiting on the processor side.
  assign oresp_val   = dropping ? 1'b0 : memresp_val;
  assign memresp_rdy = dropping ? 1'b1 : oresp_rdy;

  assign req_go  = memreq_val && memreq_rdy;
  assign resp_go = memresp_val && memresp_rdy;

  always_comb begin
    inflight_d = inflight_q;
    drop_d     = drop_q;
    // A response with nothing outstanding is a protocol error; hold at zero instead of wrapping.
    if (req_go && !resp_go) begin
      inflight_d = inflight_q + c_cnt_nbits'(1);
    end else if (!req_go && resp_go && (inflight_q != '0)) begin
      inflight_d = inflight_q - c_cnt_nbits'(1);
    end
    if (squash) begin
      drop_d = inflight_d;
    end else if (resp_go && (drop_q != '0)) begin
      drop_d = drop_q - c_cnt_nbits'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  assign num_inflight = inflight_q;

endmodule
